// File: rtl/conv1_loader.sv
// Byte-stream feeder for conv1: packs image/filter/bias into wide buses, then
// sequences the conv engine and holds its result until acknowledged.
module conv1_loader #(
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          iRst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic [6271:0] tensor_in,
    output logic [199:0]  filter_in,
    output logic [7:0]    bias_in,
    output logic          conv_ena,
    output logic          conv_rst_n,
    input  logic          conv_done,
    input  logic          conv_overflow,
    output logic          result_valid,
    output logic          result_overflow,
    output logic          result_timeout,
    input  logic          result_ack,
    output logic          busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IMG, FLT, BIAS, CRST, RUN, HOLD} state_t;

    state_t          state, state_nxt;
    logic [9:0]      idx;
    logic [CW-1:0]   cyc;
    logic            accept;

    assign in_ready = (state == IMG) || (state == FLT) || (state == BIAS);
    assign busy     = !in_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!iRst_n) state <= IMG;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IMG:  if (accept && idx == 10'd783) state_nxt = FLT;
            FLT:  if (accept && idx == 10'd24)  state_nxt = BIAS;
            BIAS: if (accept)                   state_nxt = CRST;
            CRST: state_nxt = RUN;
            RUN:  if (conv_done || cyc == CYC_LAST) state_nxt = HOLD;
            HOLD: if (result_ack && result_valid) state_nxt = IMG;
            default: state_nxt = IMG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            idx             <= '0;
            cyc             <= '0;
            tensor_in       <= '0;
            filter_in       <= '0;
            bias_in         <= '0;
            conv_ena        <= 1'b0;
            conv_rst_n      <= 1'b0;
            result_valid    <= 1'b0;
            result_overflow <= 1'b0;
            result_timeout  <= 1'b0;
        end else begin
            case (state)
                IMG: if (accept) begin
                    tensor_in[{idx, 3'b000} +: 8] <= in_data;
                    idx <= (idx == 10'd783) ? 10'd0 : idx + 10'd1;
                end
                FLT: if (accept) begin
                    filter_in[{idx[4:0], 3'b000} +: 8] <= in_data;
                    idx <= (idx == 10'd24) ? 10'd0 : idx + 10'd1;
                end
                // Engine enable and reset pulse are registered so CRST sees them immediately.
                BIAS: if (accept) begin
                    bias_in    <= in_data;
                    conv_ena   <= 1'b1;
                    conv_rst_n <= 1'b0;
                end
                CRST: begin
                    conv_rst_n <= 1'b1;
                    cyc        <= '0;
                end
                RUN: begin
                    cyc <= cyc + CW'(1);
                    if (conv_done || cyc == CYC_LAST) begin
                        result_valid    <= 1'b1;
                        result_overflow <= conv_overflow;
                        result_timeout  <= !conv_done;
                    end
                end
                // conv_ena stays high in HOLD so the engine keeps driving its outputs.
                HOLD: if (result_ack && result_valid) begin
                    result_valid <= 1'b0;
                    conv_ena     <= 1'b0;
                    conv_rst_n   <= 1'b0;
                    idx          <= '0;
                    cyc          <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1_loader.sv
// Scoreboard bench for conv1_loader: loaded bytes and engine outcomes are
// queued as driven and checked when the DUT presents buses or results.
module tb_conv1_loader;

    localparam int TIMEOUT = 1024;

    logic          clk = 1'b0;
    logic          iRst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic [6271:0] tensor_in;
    logic [199:0]  filter_in;
    logic [7:0]    bias_in;
    logic          conv_ena, conv_rst_n;
    logic          conv_done = 1'b0, conv_overflow = 1'b0;
    logic          result_valid, result_overflow, result_timeout;
    logic          result_ack = 1'b0;
    logic          busy;

    conv1_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .iRst_n(iRst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tensor_in(tensor_in), .filter_in(filter_in),
        .bias_in(bias_in), .conv_ena(conv_ena), .conv_rst_n(conv_rst_n),
        .conv_done(conv_done), .conv_overflow(conv_overflow),
        .result_valid(result_valid), .result_overflow(result_overflow),
        .result_timeout(result_timeout), .result_ack(result_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_pass = 0;
    logic [7:0] exp_q[$];
    logic [1:0] res_q[$];
    int         lat_q[$];
    logic [7:0] last_bias;
    int         load_cycles;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] frame_byte(input int i, input int kind);
        logic [31:0] v;
        case (kind)
            0: begin
                if (i < 784)      v = i;
                else if (i < 809) v = i - 783;
                else              v = 32'h3C;
            end
            1: v = i * 7 + 3;
            default: v = $urandom;
        endcase
        return v[7:0];
    endfunction

    // Drives bytes until `stop` have been offered while in_ready; accepted bytes go to the scoreboard.
    task automatic load_frame(input bit gaps, input int kind, input int stop);
        int i = 0;
        int guard = 0;
        load_cycles = 0;
        while (i < stop && guard < 10000) begin
            @(negedge clk);
            guard++;
            load_cycles++;
            if (gaps && $urandom_range(1, 0) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = frame_byte(i, kind);
                if (in_ready) begin
                    exp_q.push_back(in_data);
                    i++;
                end
            end
        end
        if (i < stop) chk("load_wait", 64'(i), 64'(stop));
    endtask

    task automatic sb_compare();
        logic [7:0] e;
        for (int i = 0; i < 810; i++) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 0, 1);
                break;
            end
            e = exp_q.pop_front();
            if (i < 784)      chk("tensor_byte", 64'(tensor_in[i*8 +: 8]), 64'(e));
            else if (i < 809) chk("filter_byte", 64'(filter_in[(i-784)*8 +: 8]), 64'(e));
            else begin
                chk("bias_byte", 64'(bias_in), 64'(e));
                last_bias = e;
            end
        end
        exp_q.delete();
    endtask

    // Called right after the bias byte has been put on the bus; ends in RUN cycle 0.
    task automatic after_load();
        @(negedge clk);
        in_data = 8'hEE;
        chk("crst_in_ready", 64'(in_ready), 0);
        chk("crst_busy", 64'(busy), 1);
        chk("crst_ena", 64'(conv_ena), 1);
        chk("crst_rst_n", 64'(conv_rst_n), 0);
        sb_compare();
        @(negedge clk);
        chk("run0_rst_n", 64'(conv_rst_n), 1);
        chk("run0_ena", 64'(conv_ena), 1);
    endtask

    // Starts in RUN cycle 0; raises conv_done during RUN cycle done_at (never if negative).
    task automatic run_engine(input int done_at, input bit ovf, input bit exp_to, input int exp_lat);
        int k = 0;
        logic [1:0] r;
        res_q.push_back({ovf, exp_to});
        lat_q.push_back(exp_lat);
        conv_overflow = ovf;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        while (!result_valid && k < 3000) begin
            conv_done = (k == done_at);
            @(negedge clk);
            k++;
        end
        conv_done = 1'b0;
        in_valid  = 1'b0;
        if (!result_valid) begin
            chk("hold_wait", 0, 1);
            res_q.delete();
            lat_q.delete();
        end else begin
            r = res_q.pop_front();
            chk("res_overflow", 64'(result_overflow), 64'(r[1]));
            chk("res_timeout", 64'(result_timeout), 64'(r[0]));
            chk("res_latency", 64'(k), 64'(lat_q.pop_front()));
            chk("hold_ena", 64'(conv_ena), 1);
            chk("hold_busy", 64'(busy), 1);
            chk("hold_bias_frozen", 64'(bias_in), 64'(last_bias));
        end
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        chk("ack_valid", 64'(result_valid), 0);
        chk("ack_ena", 64'(conv_ena), 0);
        chk("ack_rst_n", 64'(conv_rst_n), 0);
        chk("ack_in_ready", 64'(in_ready), 1);
        chk("ack_busy", 64'(busy), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 1);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_ena"}, 64'(conv_ena), 0);
        chk({tag, "_rst_n"}, 64'(conv_rst_n), 0);
        chk({tag, "_valid"}, 64'(result_valid), 0);
        chk({tag, "_ovf"}, 64'(result_overflow), 0);
        chk({tag, "_tmo"}, 64'(result_timeout), 0);
        chk({tag, "_tensor_zero"}, 64'(tensor_in == '0), 1);
        chk({tag, "_filter_zero"}, 64'(filter_in == '0), 1);
        chk({tag, "_bias"}, 64'(bias_in), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("rst");
        iRst_n = 1'b1;

        // Ramp frame, no gaps, done at RUN cycle 577 with overflow.
        load_frame(1'b0, 0, 810);
        chk("load_cycles", 64'(load_cycles), 810);
        after_load();
        chk("tensor_783", 64'(tensor_in[783*8 +: 8]), 64'h0F);
        chk("filter_24", 64'(filter_in[24*8 +: 8]), 64'h19);
        chk("bias_3c", 64'(bias_in), 64'h3C);
        run_engine(577, 1'b1, 1'b0, 578);
        do_ack();

        // Same ramp with random valid gaps, engine never finishes.
        load_frame(1'b1, 0, 810);
        after_load();
        run_engine(-1, 1'b1, 1'b1, TIMEOUT);
        do_ack();

        // Done coincides with the timeout cycle; ack held from before HOLD.
        load_frame(1'b1, 1, 810);
        after_load();
        result_ack = 1'b1;
        run_engine(TIMEOUT - 1, 1'b0, 1'b0, TIMEOUT);
        @(negedge clk);
        result_ack = 1'b0;
        chk("early_ack_valid", 64'(result_valid), 0);
        chk("early_ack_in_ready", 64'(in_ready), 1);

        // Reset mid-image at idx 300.
        load_frame(1'b0, 2, 300);
        @(negedge clk);
        in_valid = 1'b0;
        iRst_n   = 1'b0;
        @(negedge clk);
        chk_reset("rst_img");
        iRst_n = 1'b1;
        exp_q.delete();

        // Full frame, then reset mid-run.
        load_frame(1'b0, 1, 810);
        after_load();
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_run_ena", 64'(conv_ena), 1);
        iRst_n = 1'b0;
        @(negedge clk);
        chk_reset("rst_run");
        iRst_n = 1'b1;

        // Fresh frame after reset loads from byte 0.
        load_frame(1'b1, 2, 810);
        after_load();
        run_engine(5, 1'b0, 1'b0, 6);
        do_ack();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
